// File: rtl/hold_meas.sv
// hold_meas: measures the length of every high pulse on g_in (in clock cycles),
// records whether f_in was seen high during the pulse, and queues one record per
// completed pulse in a small first-word-fall-through FIFO read via valid/ready.
// Optional build macro: HOLD_MEAS_TIMEOUT_EN -- when defined, a pulse whose
// length counter saturates is recorded immediately and the rest of the pulse is
// ignored; when undefined the counter holds and the record is emitted at the
// falling edge of the pulse.
module hold_meas #(
    parameter int CNT_W = 8,
    parameter int DEPTH = 4   // power of two, minimum 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             g_in,
    input  logic             f_in,
    input  logic             clr,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [CNT_W-1:0] out_len,
    output logic             out_flag,
    output logic             out_sat,
    output logic             overflow,
    output logic             busy
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int REC_W = CNT_W + 2;
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;
    localparam logic [PTR_W:0]   FULL_CNT = (PTR_W + 1)'(DEPTH);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        MEAS     = 2'd1,
        WAIT_LOW = 2'd2
    } state_t;

    // Input sampling
    logic g_q, g_d;
    logic f_q, f_d;
    // Marks that g_q holds a real sample of g_in rather than its reset value.
    logic g_vld_q, g_vld_d;

    // Measurement FSM
    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             flag_q, flag_d;
    logic             sat_q, sat_d;
    logic             busy_q, busy_d;
    logic             push;
    logic [REC_W-1:0] rec_d;

    // Record FIFO; each entry is {len, flag, sat}
    logic [REC_W-1:0] mem_q [DEPTH];
    logic [REC_W-1:0] mem_d [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]   count_q, count_d;
    logic             overflow_q, overflow_d;
    logic             pop;
    logic             full;
    logic             push_ok;
    logic [REC_W-1:0] head;

    // Next values of the input sample registers
    always_comb begin
        g_d     = g_in;
        f_d     = f_in;
        g_vld_d = 1'b1;
    end

    // Input sample registers; g_vld_q keeps the FSM from treating the reset
    // value of g_q as a genuine low sample of a pulse held through reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            g_q     <= 1'b0;
            f_q     <= 1'b0;
            g_vld_q <= 1'b0;
        end else begin
            g_q     <= g_d;
            f_q     <= f_d;
            g_vld_q <= g_vld_d;
        end
    end

    // FSM next state, pulse counter and record generation; clr wins over a push
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        flag_d  = flag_q;
        sat_d   = sat_q;
        push    = 1'b0;
        rec_d   = {cnt_q, flag_q, sat_q};
        case (state_q)
            WAIT_LOW: begin
                if (g_vld_q && !g_q) begin
                    state_d = IDLE;
                end
            end
            IDLE: begin
                if (g_q) begin
                    state_d = MEAS;
                    cnt_d   = CNT_W'(1);
                    flag_d  = f_q;
                    sat_d   = 1'b0;
                end
            end
            MEAS: begin
                if (g_q) begin
                    flag_d = flag_q | f_q;
                    if (cnt_q == CNT_MAX) begin
                        sat_d = 1'b1;
`ifdef HOLD_MEAS_TIMEOUT_EN
                        // Emit the saturated record now and ignore the tail.
                        push    = 1'b1;
                        rec_d   = {CNT_MAX, flag_q | f_q, 1'b1};
                        state_d = WAIT_LOW;
`else
`endif
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end else begin
                    push    = 1'b1;
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = WAIT_LOW;
            end
        endcase
        if (clr) begin
            state_d = WAIT_LOW;
            push    = 1'b0;
        end
    end

    // busy is registered from the next state so it tracks state_q == MEAS
    always_comb begin
        busy_d = (state_d == MEAS);
    end

    // FSM and measurement registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= WAIT_LOW;
            cnt_q   <= '0;
            flag_q  <= 1'b0;
            sat_q   <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            flag_q  <= flag_d;
            sat_q   <= sat_d;
            busy_q  <= busy_d;
        end
    end

    // FIFO control: a full FIFO still accepts a push when the head pops in the
    // same cycle; otherwise a push on full is dropped and flagged.
    always_comb begin
        pop        = out_valid && out_ready;
        full       = (count_q == FULL_CNT);
        push_ok    = push && (!full || pop);
        mem_d      = mem_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        overflow_d = overflow_q;
        if (push_ok) begin
            mem_d[wr_ptr_q] = rec_d;
            wr_ptr_d        = wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        if (push_ok && !pop) begin
            count_d = count_q + (PTR_W + 1)'(1);
        end else if (!push_ok && pop) begin
            count_d = count_q - (PTR_W + 1)'(1);
        end
        if (push && !push_ok) begin
            overflow_d = 1'b1;
        end
        if (clr) begin
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
            count_d    = '0;
            overflow_d = 1'b0;
        end
    end

    // FIFO storage and pointer registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            mem_q      <= mem_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
        end
    end

    // Head record falls through; fields read as zero while the FIFO is empty
    always_comb begin
        out_valid = (count_q != '0);
        head      = mem_q[rd_ptr_q];
        out_len   = out_valid ? head[REC_W-1:2] : '0;
        out_flag  = out_valid ? head[1] : 1'b0;
        out_sat   = out_valid ? head[0] : 1'b0;
        overflow  = overflow_q;
        busy      = busy_q;
    end

endmodule
